// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and a
// small decode helper used when a new operation is accepted.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // True when the op needs the multi-cycle datapath (divide by zero
    // is answered in a single cycle instead).
    function automatic logic op_is_iter(input logic [2:0] op, input logic b_is_zero);
        return (op == OP_MULU) || ((op == OP_DIVU) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage control and the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, zero, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, zero, div_by_zero
    );
endinterface

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide,
// one bit per step, over a 2*WIDTH accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               div_qbit_s;

    // Next accumulator value for one multiply or divide step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        div_trial_s = acc_q[2*WIDTH-1:WIDTH-1];
        div_rem_s   = div_trial_s[WIDTH-1:0];
        div_qbit_s  = 1'b0;
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        // The trial remainder is below 2*divisor, so when it is not smaller
        // than the divisor the difference always fits in WIDTH bits.
        if (div_trial_s >= {1'b0, opnd_q}) begin
            div_rem_s  = div_trial_s[WIDTH-1:0] - opnd_q;
            div_qbit_s = 1'b1;
        end else begin
            div_rem_s  = div_trial_s[WIDTH-1:0];
            div_qbit_s = 1'b0;
        end
        if (div_q) begin
            acc_next_o = {div_rem_s, acc_q[WIDTH-2:0], div_qbit_s};
        end else begin
            acc_next_o = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
    end

    // Accumulator/operand registers: load on accept, advance on each step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= {(2*WIDTH){1'b0}};
            opnd_q <= {WIDTH{1'b0}};
            div_q  <= 1'b0;
        end else if (load_i) begin
            div_q <= div_mode_i;
            if (div_mode_i) begin
                acc_q  <= {{WIDTH{1'b0}}, a_i};
                opnd_q <= b_i;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, b_i};
                opnd_q <= a_i;
            end
        end else if (step_i) begin
            acc_q <= acc_next_o;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU for the EX stage: single-cycle logic/arith ops plus
// iterative unsigned multiply/divide behind a start/busy/done handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clock,
    input  logic     reset_n,
    alu_seq_if.slave bus
);

    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             dbz_q;

    logic [WIDTH-1:0]   sc_res_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               b_zero_s;
    logic               load_s;
    logic               step_s;

    assign b_zero_s = (bus.b == ZERO_W);
    assign load_s   = (state_q == ST_IDLE) && bus.start && op_is_iter(bus.op, b_zero_s);
    assign step_s   = (state_q == ST_MUL) || (state_q == ST_DIV);

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (load_s),
        .step_i     (step_s),
        .div_mode_i (bus.op == OP_DIVU),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .acc_next_o (acc_next_s)
    );

    // Single-cycle op results computed straight from the request inputs.
    always_comb begin
        sc_res_s = ZERO_W;
        case (bus.op)
            OP_AND:  sc_res_s = bus.a & bus.b;
            OP_OR:   sc_res_s = bus.a | bus.b;
            OP_ADD:  sc_res_s = bus.a + bus.b;
            OP_SUB:  sc_res_s = bus.a - bus.b;
            OP_SLT: begin
                if ($signed(bus.a) < $signed(bus.b)) begin
                    sc_res_s = ONE_W;
                end else begin
                    sc_res_s = ZERO_W;
                end
            end
            default: sc_res_s = ZERO_W;
        endcase
    end

    // Control FSM with the iteration counter and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= ZERO_W;
            result_hi_q <= ZERO_W;
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        dbz_q <= 1'b0;
                        cnt_q <= CNT_ZERO;
                        case (bus.op)
                            OP_MULU: begin
                                state_q <= ST_MUL;
                                busy_q  <= 1'b1;
                            end
                            OP_DIVU: begin
                                if (b_zero_s) begin
                                    result_q    <= ONES_W;
                                    result_hi_q <= bus.a;
                                    zero_q      <= 1'b0;
                                    dbz_q       <= 1'b1;
                                    done_q      <= 1'b1;
                                end else begin
                                    state_q <= ST_DIV;
                                    busy_q  <= 1'b1;
                                end
                            end
                            default: begin
                                result_q    <= sc_res_s;
                                result_hi_q <= ZERO_W;
                                zero_q      <= (sc_res_s == ZERO_W);
                                done_q      <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    // The final step is folded into the result capture so
                    // the partial accumulator never reaches the outputs.
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= CNT_ZERO;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= acc_next_s[WIDTH-1:0];
                        result_hi_q <= acc_next_s[2*WIDTH-1:WIDTH];
                        zero_q      <= (acc_next_s[WIDTH-1:0] == ZERO_W);
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vector table, handshake corner
// sequences, and random ops against an arithmetic reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(W)) bus_if ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_res;
    logic [W-1:0] last_hi;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic       dbz;
        int         offs;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: results follow from plain unsigned/signed arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [W-1:0] hi,
                         output logic dbz, output int offs);
        logic [2*W-1:0] p;
        res = 16'h0000; hi = 16'h0000; dbz = 1'b0; offs = 0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = 16'(a + b);
            OP_SUB:  res = 16'(a - b);
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
            OP_MULU: begin
                p = {16'h0000, a} * {16'h0000, b};
                res = p[W-1:0]; hi = p[2*W-1:W]; offs = W;
            end
            OP_DIVU: begin
                if (b == 16'h0000) begin
                    res = 16'hFFFF; hi = a; dbz = 1'b1;
                end else begin
                    res = a / b; hi = a % b; offs = W;
                end
            end
            default: res = 16'h0000;
        endcase
    endtask

    // Issue one op from a point away from the clock edge and follow it to done.
    // Returns with done observed high, so a following call starts back-to-back.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] hi,
                          input logic dbz, input int offs);
        int  j;
        int  busy_cnt;
        bit  seen;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.op    = 3'($urandom);
        bus_if.a     = 16'($urandom);
        bus_if.b     = 16'($urandom);
        j = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && j < 40) begin
            if (bus_if.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus_if.busy === 1'b1) busy_cnt++;
                @(posedge clk); #1;
                j++;
            end
        end
        chk({name, "/done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "/latency"}, 32'(j), 32'(offs));
            chk({name, "/busy_cycles"}, 32'(busy_cnt), 32'(offs));
            chk({name, "/busy_at_done"}, 32'(bus_if.busy), 32'd0);
            chk({name, "/result"}, 32'(bus_if.result), 32'(res));
            chk({name, "/result_hi"}, 32'(bus_if.result_hi), 32'(hi));
            chk({name, "/zero"}, 32'(bus_if.zero), 32'(res == 16'h0000));
            chk({name, "/div_by_zero"}, 32'(bus_if.div_by_zero), 32'(dbz));
        end
        last_res = res;
        last_hi  = hi;
    endtask

    // One idle cycle: done must have dropped and results must hold.
    task automatic idle_check(input string name);
        bus_if.start = 1'b0;
        @(posedge clk); #1;
        chk({name, "/done_pulse"}, 32'(bus_if.done), 32'd0);
        chk({name, "/busy_idle"}, 32'(bus_if.busy), 32'd0);
        chk({name, "/hold_res"}, 32'(bus_if.result), 32'(last_res));
        chk({name, "/hold_hi"}, 32'(bus_if.result_hi), 32'(last_hi));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "/busy"}, 32'(bus_if.busy), 32'd0);
        chk({name, "/done"}, 32'(bus_if.done), 32'd0);
        chk({name, "/result"}, 32'(bus_if.result), 32'd0);
        chk({name, "/result_hi"}, 32'(bus_if.result_hi), 32'd0);
        chk({name, "/zero"}, 32'(bus_if.zero), 32'd1);
        chk({name, "/dbz"}, 32'(bus_if.div_by_zero), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r_res;
        logic [W-1:0] r_hi;
        logic         r_dbz;
        int           r_offs;
        logic [2:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        int           dones;
        int           done_j;
        logic [W-1:0] got_res;
        logic [W-1:0] got_hi;

        vecs[0]  = '{"add15_7",    OP_ADD,  16'd15,    16'd7,     16'd22,    16'h0000, 1'b0, 0};
        vecs[1]  = '{"sub8_8",     OP_SUB,  16'h0008,  16'h0008,  16'h0000,  16'h0000, 1'b0, 0};
        vecs[2]  = '{"slt_neg",    OP_SLT,  16'hFFFF,  16'h0001,  16'h0001,  16'h0000, 1'b0, 0};
        vecs[3]  = '{"slt_swap",   OP_SLT,  16'h0001,  16'hFFFF,  16'h0000,  16'h0000, 1'b0, 0};
        vecs[4]  = '{"or_f_7",     OP_OR,   16'h000F,  16'h0007,  16'h000F,  16'h0000, 1'b0, 0};
        vecs[5]  = '{"mul300",     OP_MULU, 16'd300,   16'd300,   16'h5F90,  16'h0001, 1'b0, 16};
        vecs[6]  = '{"mulmax",     OP_MULU, 16'hFFFF,  16'hFFFF,  16'h0001,  16'hFFFE, 1'b0, 16};
        vecs[7]  = '{"div22_7",    OP_DIVU, 16'd22,    16'd7,     16'd3,     16'd1,    1'b0, 16};
        vecs[8]  = '{"div5_0",     OP_DIVU, 16'd5,     16'd0,     16'hFFFF,  16'd5,    1'b1, 0};
        vecs[9]  = '{"add_clrdbz", OP_ADD,  16'd1,     16'd2,     16'd3,     16'h0000, 1'b0, 0};
        vecs[10] = '{"and",        OP_AND,  16'hF0F0,  16'h0FF0,  16'h00F0,  16'h0000, 1'b0, 0};
        vecs[11] = '{"rsvd",       OP_RSVD, 16'h1234,  16'h5678,  16'h0000,  16'h0000, 1'b0, 0};
        vecs[12] = '{"add_wrap",   OP_ADD,  16'hFFFF,  16'h0001,  16'h0000,  16'h0000, 1'b0, 0};
        vecs[13] = '{"sub_wrap",   OP_SUB,  16'h0000,  16'h0001,  16'hFFFF,  16'h0000, 1'b0, 0};

        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op = OP_AND;
        bus_if.a = 16'h0000;
        bus_if.b = 16'h0000;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("reset");
        last_res = 16'h0000;
        last_hi  = 16'h0000;

        // Directed table, issued back-to-back on each done cycle.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].hi, vecs[i].dbz, vecs[i].offs);
        end
        idle_check("after_table");

        // Random ops against the reference model, with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            r_b  = ($urandom_range(0, 5) == 0) ? 16'h0000 :
                   (($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom));
            model(r_op, r_a, r_b, r_res, r_hi, r_dbz, r_offs);
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, r_res, r_hi, r_dbz, r_offs);
            if ($urandom_range(0, 2) == 0) idle_check($sformatf("rand%0d_idle", i));
        end

        // start pulsed at k+3 during a multiply must be ignored.
        bus_if.start = 1'b1; bus_if.op = OP_MULU; bus_if.a = 16'd300; bus_if.b = 16'd7;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        dones = 0; done_j = -1; got_res = 16'h0000; got_hi = 16'h0000;
        for (int j = 0; j < 40; j++) begin
            if (j == 2) begin
                bus_if.start = 1'b1; bus_if.op = OP_ADD; bus_if.a = 16'd1; bus_if.b = 16'd1;
            end else begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done === 1'b1) begin
                dones++; done_j = j; got_res = bus_if.result; got_hi = bus_if.result_hi;
            end
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0;
        chk("busy_start/dones", 32'(dones), 32'd1);
        chk("busy_start/latency", 32'(done_j), 32'd16);
        chk("busy_start/result", 32'(got_res), 32'd2100);
        chk("busy_start/result_hi", 32'(got_hi), 32'd0);

        // Asynchronous reset mid-divide: immediate reset values, no done.
        bus_if.start = 1'b1; bus_if.op = OP_DIVU; bus_if.a = 16'd100; bus_if.b = 16'd3;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("rst_mid/busy_before", 32'(bus_if.busy), 32'd1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 24; j++) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) dones++;
        end
        chk("rst_mid/no_done", 32'(dones), 32'd0);
        run_op("after_rst_add", OP_ADD, 16'd4, 16'd5, 16'd9, 16'h0000, 1'b0, 0);
        idle_check("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
